// File: rtl/axis_pkt_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_traffic_gen
// Brief    : AXI-Stream packet traffic source with INC / LFSR / CONST payload,
//            programmable packet length, packet count and inter-packet gap,
//            plus accepted-beat and completed-packet counters.
// Revision : 1.0 - initial release
// ============================================================================
module axis_pkt_traffic_gen #(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    LEN_WIDTH  = 8,
  parameter int                    GAP_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] SEED       = {{(DATA_WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            mode,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [15:0]           num_pkts,
  input  logic [GAP_WIDTH-1:0]  gap,
  input  logic [DATA_WIDTH-1:0] const_val,
  output logic [DATA_WIDTH-1:0] axis_tdata,
  output logic                  axis_tvalid,
  output logic                  axis_tlast,
  input  logic                  axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           beat_count,
  output logic [15:0]           pkt_count
);

  // An all-zero seed would lock the LFSR at zero, so fall back to 1.
  localparam logic [DATA_WIDTH-1:0] SEED_EFF =
    (SEED == '0) ? {{(DATA_WIDTH-1){1'b0}}, 1'b1} : SEED;

  localparam logic [1:0] MODE_LFSR  = 2'd1;
  localparam logic [1:0] MODE_CONST = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             mode_q;
  logic [LEN_WIDTH-1:0]   len_m1_q, len_m1_d;
  logic [LEN_WIDTH-1:0]   idx_q, idx_d;
  logic [15:0]            num_q;
  logic [GAP_WIDTH-1:0]   gap_q;
  logic [GAP_WIDTH-1:0]   gap_cnt_q;
  logic                   stop_q;
  logic                   done_d;

  logic                   handshake;
  logic                   is_last;
  logic                   stop_any;
  logic                   run_ending;
  logic [15:0]            pkts_next;
  logic [DATA_WIDTH-1:0]  lfsr_next;

  assign handshake  = axis_tvalid && axis_tready;
  assign is_last    = (idx_q == len_m1_q);
  assign stop_any   = stop_q || stop;
  assign pkts_next  = pkt_count + 16'd1;
  assign run_ending = stop_any || ((num_q != 16'd0) && (pkts_next == num_q));
  assign lfsr_next  = {axis_tdata[DATA_WIDTH-2:0],
                       axis_tdata[DATA_WIDTH-1] ^ axis_tdata[DATA_WIDTH-2] ^
                       axis_tdata[DATA_WIDTH-4] ^ axis_tdata[DATA_WIDTH-5]};

  // Next-state logic: run sequencing, beat index and packet-length latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_m1_d = len_m1_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SEND;
          idx_d    = '0;
          len_m1_d = (pkt_len == '0) ? '0 : pkt_len - 1'b1;
        end
      end
      S_SEND: begin
        if (handshake) begin
          if (is_last) begin
            idx_d = '0;
            if (run_ending) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else if (gap_q != '0) begin
              state_d = S_GAP;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (stop_any) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (gap_cnt_q == '0) begin
          state_d = S_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register plus registered bus/status outputs derived from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      len_m1_q    <= '0;
      axis_tvalid <= 1'b0;
      axis_tlast  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_m1_q    <= len_m1_d;
      axis_tvalid <= (state_d == S_SEND);
      axis_tlast  <= (state_d == S_SEND) && (idx_d == len_m1_d);
      busy        <= (state_d != S_IDLE);
      done        <= done_d;
    end
  end

  // Configuration latch, payload generator, counters, gap timer, sticky stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= 2'd0;
      num_q      <= 16'd0;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
      stop_q     <= 1'b0;
      axis_tdata <= '0;
      beat_count <= 32'd0;
      pkt_count  <= 16'd0;
    end else begin
      if ((state_q == S_IDLE) && start) begin
        mode_q     <= mode;
        num_q      <= num_pkts;
        gap_q      <= gap;
        beat_count <= 32'd0;
        pkt_count  <= 16'd0;
        stop_q     <= 1'b0;
        unique case (mode)
          MODE_LFSR:  axis_tdata <= SEED_EFF;
          MODE_CONST: axis_tdata <= const_val;
          default:    axis_tdata <= '0;
        endcase
      end

      if (handshake) begin
        beat_count <= beat_count + 32'd1;
        if (mode_q == MODE_LFSR) begin
          axis_tdata <= lfsr_next;
        end else if (mode_q != MODE_CONST) begin
          axis_tdata <= axis_tdata + 1'b1;
        end
        if (is_last) begin
          pkt_count <= pkts_next;
          // Loaded with gap-1 so GAP lasts exactly gap cycles.
          gap_cnt_q <= gap_q - 1'b1;
        end
      end else if ((state_q == S_GAP) && (gap_cnt_q != '0)) begin
        gap_cnt_q <= gap_cnt_q - 1'b1;
      end

      if (state_q != S_IDLE) begin
        if (state_d == S_IDLE) begin
          stop_q <= 1'b0;
        end else if (stop) begin
          stop_q <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_pkt_traffic_gen
// Brief    : Scoreboard bench for axis_pkt_traffic_gen (DATA_WIDTH = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_pkt_traffic_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  pkt_len = 8'd0;
  logic [15:0] num_pkts = 16'd0;
  logic [7:0]  gap = 8'd0;
  logic [7:0]  const_val = 8'd0;
  logic [7:0]  axis_tdata;
  logic        axis_tvalid;
  logic        axis_tlast;
  logic        axis_tready = 1'b1;
  logic        busy;
  logic        done;
  logic [31:0] beat_count;
  logic [15:0] pkt_count;

  axis_pkt_traffic_gen #(
    .DATA_WIDTH(8), .LEN_WIDTH(8), .GAP_WIDTH(8), .SEED(8'h01)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .pkt_len(pkt_len), .num_pkts(num_pkts), .gap(gap), .const_val(const_val),
    .axis_tdata(axis_tdata), .axis_tvalid(axis_tvalid), .axis_tlast(axis_tlast),
    .axis_tready(axis_tready), .busy(busy), .done(done),
    .beat_count(beat_count), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];     // {tlast, tdata}
  int mon_hs = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  int done_cyc = 0;
  int done_pulses = 0;
  int stall_cnt = 0;
  int exp_gap = 0;
  int tr_mode = 0;          // 0 always ready, 1 random, 2 directed

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference payload for beat k of a run, straight from the mode rules.
  function automatic logic [7:0] model_data(input int m, input int k, input logic [7:0] cv);
    logic [7:0] x;
    if (m == 2) return cv;
    if (m == 1) begin
      x = 8'h01;
      for (int i = 0; i < k; i++) x = {x[6:0], x[7] ^ x[6] ^ x[4] ^ x[3]};
      return x;
    end
    return 8'(k);
  endfunction

  // Ready driver for the non-directed modes.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (tr_mode == 1) axis_tready = ($urandom_range(0, 3) != 0);
      else if (tr_mode == 0) axis_tready = 1'b1;
    end
  end

  // Monitor: scoreboard pops on handshake, AXIS hold rule, gap length, done.
  bit in_gap = 0;
  int low = 0;
  bit prev_stall = 0;
  logic [7:0] prev_d;
  logic prev_l;
  logic [8:0] e;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      in_gap = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall)
        chk(axis_tvalid && axis_tdata == prev_d && axis_tlast == prev_l, "hold",
            {axis_tvalid, axis_tlast, axis_tdata}, {1'b1, prev_l, prev_d});
      if (axis_tvalid) begin
        if (in_gap) chk(low == exp_gap, "gap_len", low, exp_gap);
        in_gap = 0;
      end else if (in_gap) begin
        low++;
      end
      if (!busy) in_gap = 0;
      if (axis_tvalid && !axis_tready && axis_tdata == 8'd2) stall_cnt++;
      if (axis_tvalid && axis_tready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_beat", axis_tdata, -1);
        end else begin
          e = exp_q.pop_front();
          chk({axis_tlast, axis_tdata} == e, "beat", {axis_tlast, axis_tdata}, e);
        end
        mon_hs++;
        last_hs_cyc = cyc;
        if (axis_tlast) begin
          in_gap = 1;
          low = 0;
        end
      end
      if (done) begin
        done_pulses++;
        done_cyc = cyc;
      end
      prev_stall = axis_tvalid && !axis_tready;
      prev_d = axis_tdata;
      prev_l = axis_tlast;
    end
  end

  task automatic launch(input int m, input int len, input int np, input int g,
                        input logic [7:0] cv, input int np_model);
    int le;
    le = (len == 0) ? 1 : len;
    mon_hs = 0;
    exp_gap = g;
    for (int k = 0; k < le * np_model; k++)
      exp_q.push_back({(k % le) == le - 1, model_data(m, k, cv)});
    @(posedge clk); #1;
    mode = 2'(m); pkt_len = 8'(len); num_pkts = 16'(np); gap = 8'(g); const_val = cv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble config to show it was latched.
    mode = 2'($urandom); pkt_len = 8'($urandom); num_pkts = 16'($urandom);
    gap = 8'($urandom); const_val = 8'($urandom);
    @(negedge clk);
    chk(busy && axis_tvalid, "start_busy_valid", {busy, axis_tvalid}, 3);
  endtask

  // Returns on the rising edge where the n-th accepted beat completes.
  task automatic wait_hs(input int n);
    int i;
    i = 0;
    @(posedge clk);
    while (mon_hs < n && i < 3000) begin
      @(posedge clk);
      i++;
    end
    if (mon_hs < n) chk(1'b0, "wait_hs_timeout", mon_hs, n);
  endtask

  task automatic finish_run(input int exp_beats, input int exp_pkts, input int lag);
    bit seen;
    int d0;
    seen = 0;
    d0 = done_pulses;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    chk(seen, "done_seen", seen, 1);
    @(negedge clk);
    chk(done == 1'b0, "done_one_cycle", done, 0);
    chk(done_cyc == last_hs_cyc + lag, "done_timing", done_cyc - last_hs_cyc, lag);
    chk(beat_count == 32'(exp_beats), "beat_count", beat_count, exp_beats);
    chk(pkt_count == 16'(exp_pkts), "pkt_count", pkt_count, exp_pkts);
    chk(!busy && !axis_tvalid && !axis_tlast, "idle_after_done",
        {busy, axis_tvalid, axis_tlast}, 0);
    chk(exp_q.size() == 0, "beats_outstanding", exp_q.size(), 0);
    chk(done_pulses - d0 == 1, "done_pulses", done_pulses - d0, 1);
    exp_q.delete();
  endtask

  initial begin
    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(axis_tdata == 8'd0 && !axis_tvalid && !axis_tlast, "reset_bus",
        {axis_tvalid, axis_tlast, axis_tdata}, 0);
    chk(!busy && !done, "reset_status", {busy, done}, 0);
    chk(beat_count == 0 && pkt_count == 0, "reset_counts", beat_count + pkt_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // INC back-to-back.
    tr_mode = 0;
    launch(0, 4, 2, 0, 8'h00, 2);
    finish_run(8, 2, 1);

    // Backpressure on beat 2.
    tr_mode = 2;
    axis_tready = 1'b1;
    stall_cnt = 0;
    launch(0, 4, 2, 0, 8'h00, 2);
    wait_hs(2); #1;
    axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1 axis_tready = 1'b1;
    finish_run(8, 2, 1);
    chk(stall_cnt == 3, "stall_cycles", stall_cnt, 3);
    tr_mode = 0;

    // LFSR.
    launch(1, 5, 1, 0, 8'h00, 1);
    finish_run(5, 1, 1);

    // Gap + CONST, with an ignored start mid-run.
    launch(2, 2, 3, 3, 8'hA5, 3);
    wait_hs(3); #1;
    mode = 2'd0; pkt_len = 8'd7; num_pkts = 16'd9; gap = 8'd0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    finish_run(6, 3, 1);

    // Continuous with stop mid-packet 2.
    launch(0, 3, 0, 0, 8'h00, 2);
    wait_hs(4); #1;
    stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    finish_run(6, 2, 1);

    // Stop while in GAP: immediate end, no further beats.
    launch(0, 2, 0, 4, 8'h00, 1);
    wait_hs(2); #1;
    stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    finish_run(2, 1, 2);

    // Reset mid-run during beat 1, then restart INC from 0.
    launch(0, 4, 2, 0, 8'h00, 2);
    wait_hs(1); #1;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk(axis_tdata == 8'd0 && !axis_tvalid && !axis_tlast && !busy && !done,
        "rst_mid_outputs", {axis_tvalid, axis_tlast, busy, done, axis_tdata}, 0);
    chk(beat_count == 0 && pkt_count == 0, "rst_mid_counts", beat_count + pkt_count, 0);
    exp_q.delete();
    launch(0, 3, 1, 0, 8'h00, 1);
    finish_run(3, 1, 1);

    // Randomized runs with random backpressure.
    tr_mode = 1;
    for (int r = 0; r < 8; r++) begin
      int m, len, np, g;
      logic [7:0] cv;
      m   = $urandom_range(0, 3);
      len = $urandom_range(0, 6);
      np  = $urandom_range(1, 3);
      g   = $urandom_range(0, 3);
      cv  = 8'($urandom);
      launch(m, len, np, g, cv, np);
      finish_run(((len == 0) ? 1 : len) * np, np, 1);
    end
    tr_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_pkt_traffic_gen.md
# axis_pkt_traffic_gen

Parametrised AXI-Stream packet traffic source for NoC and MVM bench stimulus. It generates framed packets with `tlast`, a selectable payload pattern (incrementing, LFSR or constant), a programmable packet length, packet count and inter-packet gap. It also keeps accepted-beat and packet counters for scoreboarding. It drives the slave-side AXIS port of the unit under test in place of the earlier free-running incrementor.

## Interface
- DATA_WIDTH, 64, `tdata` width; must be at least 8.
- LEN_WIDTH, 8, width of `pkt_len`.
- GAP_WIDTH, 8, width of `gap`.
- SEED, 1, LFSR initial value (low DATA_WIDTH bits). If these bits are 0, the block uses 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that latches the configuration and begins a run. Ignored while `busy`.
- stop  in  1  request to end the run after the current packet. Sticky until the run ends.
- mode  in  2  payload mode: 0 INC, 1 LFSR, 2 CONST, 3 treated as INC.
- pkt_len  in  LEN_WIDTH  beats per packet. A value of 0 is treated as 1.
- num_pkts  in  16  packets per run. A value of 0 means continuous until `stop`.
- gap  in  GAP_WIDTH  idle cycles between packets.
- const_val  in  DATA_WIDTH  payload in CONST mode.
- axis_tdata  out  DATA_WIDTH  payload.
- axis_tvalid  out  1  beat valid.
- axis_tlast  out  1  last beat of packet.
- axis_tready  in  1  downstream ready.
- busy  out  1  high from the cycle after `start` until the run ends.
- done  out  1  one-cycle pulse when the run ends.
- beat_count  out  32  accepted beats this run; wraps.
- pkt_count  out  16  completed packets this run; wraps.

## Operation
- A handshake is `axis_tvalid && axis_tready` at a rising edge.
- FSM states:
  - IDLE: on `start`, latch `mode`, `pkt_len`, `num_pkts`, `gap` and `const_val`. Clear both counters and the beat index. Load the generator (0 for INC, SEED for LFSR). Go to SEND.
  - SEND: `tvalid` is 1. On handshake, increment `beat_count` and advance the generator.
    - If the beat index equals the latched length minus 1, this is the last beat:
      - increment `pkt_count` and reset the beat index;
      - if the run is ending, go to IDLE and pulse `done`;
      - otherwise, if `gap` > 0, go to GAP; if `gap` = 0, stay in SEND.
    - Otherwise, increment the beat index.
  - GAP: `tvalid` is 0. A counter runs for exactly `gap` cycles, then the FSM returns to SEND.
- The run is ending when `stop` is pending, or when `num_pkts` ≠ 0 and the completed count reaches `num_pkts`.
- `stop` never truncates a packet. If `stop` arrives in GAP, go to IDLE at once with `done` and no further beats.
- `axis_tlast` is 1 exactly when in SEND and the beat index equals length minus 1.
- Payload per mode:
  - INC: `tdata` starts at 0 and increments by 1 per handshake, wrapping mod 2^DATA_WIDTH.
  - LFSR: on each handshake, `x <= {x[DW-2:0], x[DW-1]^x[DW-2]^x[DW-4]^x[DW-5]}`.
  - CONST: `tdata` is always the latched `const_val`.
- The generator advances only on handshake. It continues across packet boundaries within a run and restarts on each `start`.

## Timing
- All outputs are registered.
- Reset values: `axis_tdata` 0, `axis_tvalid` 0, `axis_tlast` 0, `busy` 0, `done` 0, `beat_count` 0, `pkt_count` 0, FSM in IDLE.
- `start` sampled at edge N gives `tvalid` = 1 and `busy` = 1 after edge N, so the first beat is presentable in cycle N+1.
- AXIS stability: while `tvalid && !tready`, `tdata` and `tlast` hold and `tvalid` stays high.
- With `tready` held at 1 and `gap` = 0, the block sends one beat per cycle, with no bubbles between packets.
- With `gap` = G, the bus shows exactly G `tvalid`-low cycles between the last-beat handshake and the next first beat.
- On the final handshake at edge M: `tvalid`, `tlast` and `busy` go to 0 after M. `done` is 1 for the single cycle after M. `start` is accepted from that cycle onward.
- `start` while `busy` has no effect.
- `rst` during a run returns every output to its reset value at the next edge and abandons any partial packet.

## Test plan
- **INC, back-to-back:** DW = 8, `pkt_len` = 4, `num_pkts` = 2, `gap` = 0, `tready` = 1. Expect 8 consecutive beats, `tdata` 0..7, `tlast` on beats 3 and 7. Expect `done` one cycle after the last beat, `beat_count` = 8, `pkt_count` = 2.
- **Backpressure:** same as above, with `tready` low for 3 cycles while beat 2 is valid. Expect `tdata` = 2 with `tvalid` = 1 for all 3 cycles and no skipped or duplicated value.
- **LFSR:** DW = 8, SEED = 1, `pkt_len` = 5, `num_pkts` = 1. Expect `tdata` 0x01, 0x02, 0x04, 0x08, 0x11, with `tlast` on 0x11.
- **Gap and CONST:** `const_val` = 0xA5, `pkt_len` = 2, `num_pkts` = 3, `gap` = 3. Expect every beat to be 0xA5 and exactly 3 `tvalid`-low cycles between packets. Expect `busy` = 0 after `done`.
- **Continuous with stop:** `num_pkts` = 0, `pkt_len` = 3, `stop` pulsed mid-packet 2. Expect packet 2 to complete with `tlast`, no packet 3, `pkt_count` = 2, and one `done` pulse.
- **Reset mid-run:** assert `rst` for 1 cycle during beat 1 of a 4-beat packet. Expect all outputs 0 next cycle. Expect a subsequent `start` in INC mode to restart `tdata` at 0.
